wash_sequencer: RTL and testbench

- Program sequencer for the washing-machine datapath. Sequences the paid wash program FILL -> WASH -> RINSE -> SPIN -> DONE.
- Starts on the payment-confirmed pulse from the billing block. Counts each phase down in 1 s ticks and handles pause/resume and door interlock.
- Drives phase/remaining-time outputs for the display and LED bars, plus the completion buzzer enable.

---
 rtl/wash_pkg.sv | 63 ++++++
 rtl/wash_sequencer_tick_gen.sv | 42 ++++
 rtl/wash_sequencer.sv | 176 +++++++++++++++++
 tb/tb_wash_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the washing-machine program sequencer:
//   - phase_t : phase encoding shown on the display (IDLE..PAUSE)
//   - MODE_*  : wash-size codes sampled when a paid program starts
//   - *_SEC   : phase durations in seconds, per mode
//   - dur()   : duration lookup for a (phase, mode) pair
// -----------------------------------------------------------------------------
package wash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5,
        PH_PAUSE = 3'd6
    } phase_t;

    localparam logic [1:0] MODE_SPIN   = 2'b00;
    localparam logic [1:0] MODE_SMALL  = 2'b01;
    localparam logic [1:0] MODE_MEDIUM = 2'b10;
    localparam logic [1:0] MODE_LARGE  = 2'b11;

    localparam logic [7:0] FILL_S_SEC  = 8'd4;
    localparam logic [7:0] FILL_M_SEC  = 8'd5;
    localparam logic [7:0] FILL_L_SEC  = 8'd6;
    localparam logic [7:0] WASH_S_SEC  = 8'd6;
    localparam logic [7:0] WASH_M_SEC  = 8'd8;
    localparam logic [7:0] WASH_L_SEC  = 8'd10;
    localparam logic [7:0] RINSE_S_SEC = 8'd4;
    localparam logic [7:0] RINSE_M_SEC = 8'd5;
    localparam logic [7:0] RINSE_L_SEC = 8'd6;
    localparam logic [7:0] SPIN_S_SEC  = 8'd3;
    localparam logic [7:0] SPIN_M_SEC  = 8'd4;
    localparam logic [7:0] SPIN_L_SEC  = 8'd5;
    localparam logic [7:0] SPIN_ONLY_SEC = 8'd5;

    // Seconds to load into remain when entering phase ph under mode m.
    // Spin-only mode never visits FILL/WASH/RINSE, so those return 0.
    function automatic logic [7:0] dur(input phase_t ph, input logic [1:0] m);
        logic [7:0] d;
        d = 8'd0;
        case (ph)
            PH_FILL:  d = (m == MODE_SMALL)  ? FILL_S_SEC  :
                          (m == MODE_MEDIUM) ? FILL_M_SEC  :
                          (m == MODE_LARGE)  ? FILL_L_SEC  : 8'd0;
            PH_WASH:  d = (m == MODE_SMALL)  ? WASH_S_SEC  :
                          (m == MODE_MEDIUM) ? WASH_M_SEC  :
                          (m == MODE_LARGE)  ? WASH_L_SEC  : 8'd0;
            PH_RINSE: d = (m == MODE_SMALL)  ? RINSE_S_SEC :
                          (m == MODE_MEDIUM) ? RINSE_M_SEC :
                          (m == MODE_LARGE)  ? RINSE_L_SEC : 8'd0;
            PH_SPIN:  d = (m == MODE_SMALL)  ? SPIN_S_SEC  :
                          (m == MODE_MEDIUM) ? SPIN_M_SEC  :
                          (m == MODE_LARGE)  ? SPIN_L_SEC  : SPIN_ONLY_SEC;
            default:  d = 8'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wash_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// One-second tick generator. The counter runs 0..TICK_CYCLES-1 while run=1 and
// tick is high on the cycle it sits at TICK_CYCLES-1 (then it wraps to 0).
// clr forces the count back to 0; with run=0 the count holds.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   run  : advance the counter this cycle
//   clr  : clear the counter (wins over run)
//   tick : one-cycle pulse per TICK_CYCLES running cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
// Paid wash program sequencer: FILL -> WASH -> RINSE -> SPIN -> DONE, counted
// down in 1 s ticks, with pause/resume, door interlock and completion buzzer.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   on           : power enable, 0 freezes every register
//   start        : payment-confirmed pulse (accepted only in IDLE, door shut)
//   pause_p      : pause/resume pulse
//   mode         : 00 spin-only, 01 small, 10 medium, 11 large
//   door_closed  : 1 = door shut
//   phase        : current phase code (wash_pkg::phase_t)
//   remain       : seconds left in the current phase
//   busy, done   : program running/paused, program finished
//   buzz_en      : completion buzzer enable
//   wt_light     : thermometer bar of remain, saturating at 8 lights
// -----------------------------------------------------------------------------
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_CYCLES   = 100000000,
    parameter int DONE_BUZZ_SEC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic       start,
    input  logic       pause_p,
    input  logic [1:0] mode,
    input  logic       door_closed,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       busy,
    output logic       done,
    output logic       buzz_en,
    output logic [7:0] wt_light
);

    localparam int BW = (DONE_BUZZ_SEC > 1) ? $clog2(DONE_BUZZ_SEC) : 1;

    phase_t        state_q, state_d, saved_q, saved_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    remain_d;
    logic          busy_d, done_d, buzz_d;
    logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic          door_q;
    logic          tick, run, clr;
    logic          running, hold_evt, start_acc, resume;

    assign running   = (state_q == PH_FILL) || (state_q == PH_WASH) ||
                       (state_q == PH_RINSE) || (state_q == PH_SPIN);
    // An open door or a pause pulse freezes the phase; it beats a same-cycle tick.
    assign hold_evt  = running && (pause_p || !door_closed);
    assign start_acc = (state_q == PH_IDLE) && start && door_closed;
    assign resume    = (state_q == PH_PAUSE) && pause_p && door_closed;

    // Counter only advances while a phase is actually counting (or buzzing in DONE).
    assign run = on && ((running && !hold_evt) || (state_q == PH_DONE));
    assign clr = on && (start_acc || resume);

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        saved_d    = saved_q;
        mode_d     = mode_q;
        remain_d   = remain;
        buzz_d     = buzz_en;
        buzz_cnt_d = buzz_cnt_q;

        case (state_q)
            PH_IDLE: begin
                if (start_acc) begin
                    mode_d = mode;
                    if (mode == MODE_SPIN) begin
                        state_d  = PH_SPIN;
                        remain_d = dur(PH_SPIN, mode);
                    end else begin
                        state_d  = PH_FILL;
                        remain_d = dur(PH_FILL, mode);
                    end
                end
            end
            PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
                if (hold_evt) begin
                    state_d = PH_PAUSE;
                    saved_d = state_q;
                end else if (tick) begin
                    if (remain > 8'd1) begin
                        remain_d = remain - 8'd1;
                    end else begin
                        // Last second of the phase: step straight to the next
                        // one so remain never displays 0 while running.
                        case (state_q)
                            PH_FILL:  begin state_d = PH_WASH;  remain_d = dur(PH_WASH, mode_q);  end
                            PH_WASH:  begin state_d = PH_RINSE; remain_d = dur(PH_RINSE, mode_q); end
                            PH_RINSE: begin state_d = PH_SPIN;  remain_d = dur(PH_SPIN, mode_q);  end
                            default: begin
                                state_d    = PH_DONE;
                                remain_d   = 8'd0;
                                buzz_d     = 1'b1;
                                buzz_cnt_d = '0;
                            end
                        endcase
                    end
                end
            end
            PH_PAUSE: begin
                if (resume) begin
                    state_d = saved_q;
                end
            end
            PH_DONE: begin
                if (tick && buzz_en) begin
                    if (buzz_cnt_q == BW'(DONE_BUZZ_SEC - 1)) begin
                        buzz_d = 1'b0;
                    end else begin
                        buzz_cnt_d = buzz_cnt_q + BW'(1);
                    end
                end
                // Laundry removed (door falls), or door left open once the buzz ends.
                if (!door_closed && (door_q || !buzz_d)) begin
                    state_d = PH_IDLE;
                    buzz_d  = 1'b0;
                end
            end
            default: state_d = PH_IDLE;
        endcase

        busy_d = (state_d == PH_FILL) || (state_d == PH_WASH) || (state_d == PH_RINSE) ||
                 (state_d == PH_SPIN) || (state_d == PH_PAUSE);
        done_d = (state_d == PH_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PH_IDLE;
            saved_q    <= PH_IDLE;
            mode_q     <= MODE_SPIN;
            remain     <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            buzz_en    <= 1'b0;
            buzz_cnt_q <= '0;
            door_q     <= 1'b0;
        end else if (on) begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            mode_q     <= mode_d;
            remain     <= remain_d;
            busy       <= busy_d;
            done       <= done_d;
            buzz_en    <= buzz_d;
            buzz_cnt_q <= buzz_cnt_d;
            door_q     <= door_closed;
        end
    end

    assign phase = state_q;

    always_comb begin
        wt_light = 8'd0;
        for (int i = 0; i < 8; i++) begin
            wt_light[i] = (remain >= 8'(i + 1));
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
// Self-checking bench for wash_sequencer with TICK_CYCLES=4, DONE_BUZZ_SEC=3.
// Inputs change on the falling clock edge; outputs are compared on the falling
// edge after the requested number of rising edges.
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

    localparam int TICK_CYCLES   = 4;
    localparam int DONE_BUZZ_SEC = 3;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] WASH  = 3'd2;
    localparam logic [2:0] RINSE = 3'd3;
    localparam logic [2:0] SPIN  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] PAUSE = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       on = 1'b1;
    logic       start = 1'b0;
    logic       pause_p = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       door_closed = 1'b1;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       busy, done, buzz_en;
    logic [7:0] wt_light;

    always #5 clk = ~clk;

    wash_sequencer #(.TICK_CYCLES(TICK_CYCLES), .DONE_BUZZ_SEC(DONE_BUZZ_SEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .start       (start),
        .pause_p     (pause_p),
        .mode        (mode),
        .door_closed (door_closed),
        .phase       (phase),
        .remain      (remain),
        .busy        (busy),
        .done        (done),
        .buzz_en     (buzz_en),
        .wt_light    (wt_light)
    );

    typedef struct {
        logic       o, s, p;
        logic [1:0] m;
        logic       d;
        int         cyc;
        logic [2:0] ph;
        logic [7:0] rem;
        logic       bsy, dn, bz;
    } vec_t;

    typedef struct {
        logic [2:0] ph;
        logic [7:0] rem;
        logic       bsy, dn, bz;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] bar_of(input logic [7:0] r);
        if (r >= 8'd8) return 8'hFF;
        return (8'd1 << r) - 8'd1;
    endfunction

    function automatic vec_t mk(input logic o, s, p, input logic [1:0] m, input logic d,
                                input int cyc, input logic [2:0] ph, input logic [7:0] rem,
                                input logic bsy, dn, bz);
        vec_t v;
        v.o = o; v.s = s; v.p = p; v.m = m; v.d = d; v.cyc = cyc;
        v.ph = ph; v.rem = rem; v.bsy = bsy; v.dn = dn; v.bz = bz;
        return v;
    endfunction

    task automatic push_exp(input logic [2:0] ph, input logic [7:0] rem, input logic bsy, dn, bz);
        exp_t e;
        e.ph = ph; e.rem = rem; e.bsy = bsy; e.dn = dn; e.bz = bz;
        sb.push_back(e);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, " phase"},    {5'd0, phase},   {5'd0, e.ph});
        check({tag, " remain"},   remain,          e.rem);
        check({tag, " busy"},     {7'd0, busy},    {7'd0, e.bsy});
        check({tag, " done"},     {7'd0, done},    {7'd0, e.dn});
        check({tag, " buzz_en"},  {7'd0, buzz_en}, {7'd0, e.bz});
        check({tag, " wt_light"}, wt_light,        bar_of(e.rem));
    endtask

    // Called on a falling edge: apply inputs (pulses last one rising edge),
    // run cyc rising edges, then compare on the falling edge.
    task automatic step(input string tag, input vec_t v);
        push_exp(v.ph, v.rem, v.bsy, v.dn, v.bz);
        on = v.o; start = v.s; pause_p = v.p; mode = v.m; door_closed = v.d;
        @(negedge clk);
        start = 1'b0;
        pause_p = 1'b0;
        repeat (v.cyc - 1) @(negedge clk);
        compare_pop(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst is held low.
        #12;
        push_exp(IDLE, 8'd0, 1'b0, 1'b0, 1'b0);
        compare_pop("reset");
        @(negedge clk);
        rst = 1'b1;

        //        o  s  p  m      d  cyc ph     rem  bsy dn bz
        // Mode 01 full program; DONE 68 cycles after start, buzz for 12 cycles.
        vecs.push_back(mk(1, 1, 0, 2'b01, 1, 1,  FILL,  8'd4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 4,  FILL,  8'd3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 11, FILL,  8'd1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 1,  WASH,  8'd6, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 24, RINSE, 8'd4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 16, SPIN,  8'd3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 11, SPIN,  8'd1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 1,  DONE,  8'd0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 11, DONE,  8'd0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'b01, 1, 1,  DONE,  8'd0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 2'b01, 0, 1,  IDLE,  8'd0, 0, 0, 0));
        // Start with door open is ignored.
        vecs.push_back(mk(1, 1, 0, 2'b01, 0, 2,  IDLE,  8'd0, 0, 0, 0));
        // Mode 00: straight to SPIN 5; later mode changes have no effect.
        vecs.push_back(mk(1, 1, 0, 2'b00, 1, 1,  SPIN,  8'd5, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b11, 1, 4,  SPIN,  8'd4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b10, 1, 15, SPIN,  8'd1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b10, 1, 1,  DONE,  8'd0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'b10, 0, 1,  IDLE,  8'd0, 0, 0, 0));
        // Mode 01 again; a start pulse during FILL changes nothing.
        vecs.push_back(mk(1, 1, 0, 2'b01, 1, 1,  FILL,  8'd4, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2'b10, 1, 4,  FILL,  8'd3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b10, 1, 12, WASH,  8'd6, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b10, 1, 4,  WASH,  8'd5, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b10, 1, 3,  WASH,  8'd5, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Pause coincident with a tick in WASH: held at 5 for 40 cycles, then
        // resume and see the next decrement exactly 4 cycles later.
        step("pause_on_tick",  mk(1, 0, 1, 2'b10, 1, 1,  PAUSE, 8'd5, 1, 0, 0));
        step("pause_hold40",   mk(1, 0, 0, 2'b10, 1, 40, PAUSE, 8'd5, 1, 0, 0));
        step("resume_wash",    mk(1, 0, 1, 2'b10, 1, 1,  WASH,  8'd5, 1, 0, 0));
        step("resume_plus3",   mk(1, 0, 0, 2'b10, 1, 3,  WASH,  8'd5, 1, 0, 0));
        step("resume_plus4",   mk(1, 0, 0, 2'b10, 1, 1,  WASH,  8'd4, 1, 0, 0));
        step("rinse_entry",    mk(1, 0, 0, 2'b10, 1, 16, RINSE, 8'd4, 1, 0, 0));
        step("rinse_pre_tick", mk(1, 0, 0, 2'b10, 1, 3,  RINSE, 8'd4, 1, 0, 0));
        // Door opens on a tick edge: pause wins, no decrement.
        step("door_open",      mk(1, 0, 0, 2'b10, 0, 1,  PAUSE, 8'd4, 1, 0, 0));
        step("pause_door_open",mk(1, 0, 1, 2'b10, 0, 3,  PAUSE, 8'd4, 1, 0, 0));
        step("door_closed",    mk(1, 0, 0, 2'b10, 1, 3,  PAUSE, 8'd4, 1, 0, 0));
        step("resume_rinse",   mk(1, 0, 1, 2'b10, 1, 1,  RINSE, 8'd4, 1, 0, 0));
        step("rinse_plus3",    mk(1, 0, 0, 2'b10, 1, 3,  RINSE, 8'd4, 1, 0, 0));
        step("rinse_plus4",    mk(1, 0, 0, 2'b10, 1, 1,  RINSE, 8'd3, 1, 0, 0));
        step("spin_entry",     mk(1, 0, 0, 2'b10, 1, 12, SPIN,  8'd3, 1, 0, 0));

        // Asynchronous reset between clock edges during SPIN.
        #2;
        rst = 1'b0;
        #1;
        push_exp(IDLE, 8'd0, 1'b0, 1'b0, 1'b0);
        compare_pop("async_reset");
        @(negedge clk);
        rst = 1'b1;

        // Mode 10; on=0 for 20 cycles mid-WASH with pulses that must be dropped.
        step("m10_fill",       mk(1, 1, 0, 2'b10, 1, 1,  FILL,  8'd5, 1, 0, 0));
        step("m10_wash",       mk(1, 0, 0, 2'b10, 1, 20, WASH,  8'd8, 1, 0, 0));
        step("m10_wash7",      mk(1, 0, 0, 2'b10, 1, 4,  WASH,  8'd7, 1, 0, 0));
        step("m10_pre_off",    mk(1, 0, 0, 2'b10, 1, 2,  WASH,  8'd7, 1, 0, 0));
        step("off_pause_drop", mk(0, 0, 1, 2'b10, 1, 1,  WASH,  8'd7, 1, 0, 0));
        step("off_hold",       mk(0, 1, 0, 2'b10, 1, 19, WASH,  8'd7, 1, 0, 0));
        step("on_again",       mk(1, 0, 0, 2'b10, 1, 1,  WASH,  8'd7, 1, 0, 0));
        step("on_tick",        mk(1, 0, 0, 2'b10, 1, 1,  WASH,  8'd6, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
